// File: rtl/sid_voice_bank.sv
// rtl/sid_voice_bank.sv - time-multiplexed SID-style oscillator/waveform bank
// Ports:
//   clock, reset_n        : single clock, asynchronous active-low reset
//   ce_1m                 : tick strobe; starts one burst of VOICES slots
//   wr_en/wr_voice/wr_reg/wr_data : byte-wide register writes
//   out_valid/out_voice/out_wave  : one registered sample per processed voice
//   osc_msb               : accumulator MSB of every voice
//   overrun               : sticky, tick arrived while a burst was running
module sid_voice_bank #(
    parameter int VOICES   = 3,
    parameter int ACC_W    = 24,
    parameter int WAVE_W   = 12,
    parameter int HOLD_TTL = 200000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ce_1m,
    input  logic              wr_en,
    input  logic [2:0]        wr_voice,
    input  logic [2:0]        wr_reg,
    input  logic [7:0]        wr_data,
    output logic              out_valid,
    output logic [2:0]        out_voice,
    output logic [WAVE_W-1:0] out_wave,
    output logic [VOICES-1:0] osc_msb,
    output logic              overrun
);

    localparam int HOLD_W = ($clog2(HOLD_TTL + 1) < 1) ? 1 : $clog2(HOLD_TTL + 1);
    // Pulse comparator width: 12 bits, or the whole sample if it is narrower.
    localparam int PW_W = (WAVE_W < 12) ? WAVE_W : 12;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [15:0]       freq  [VOICES];
    logic [11:0]       pw    [VOICES];
    logic [7:0]        ctrl  [VOICES];
    logic [ACC_W-1:0]  acc   [VOICES];
    logic [22:0]       lfsr  [VOICES];
    logic [WAVE_W-1:0] last  [VOICES];
    logic [HOLD_W-1:0] hold  [VOICES];
    logic [VOICES-1:0] msb_d1, msb_d2, nclk;

    logic [0:0] state;
    logic [2:0] slot;

    // Registers of the voice in the current slot and its sync source.
    logic [15:0]       cur_freq;
    logic [11:0]       cur_pw;
    logic [7:0]        cur_ctrl;
    logic [ACC_W-1:0]  cur_acc;
    logic [22:0]       cur_lfsr;
    logic [WAVE_W-1:0] cur_last;
    logic [HOLD_W-1:0] cur_hold;
    logic              cur_nclk, src_d1, src_d2;

    logic              test, sync, fold;
    logic [ACC_W-1:0]  acc_nxt;
    logic [22:0]       lfsr_nxt;
    logic [WAVE_W-1:0] saw_w, tri_w, pulse_w, noise_w, mix, sample, last_nxt;
    logic [7:0]        noise8;
    logic [HOLD_W-1:0] hold_nxt;

    for (genvar g = 0; g < VOICES; g++) begin : g_msb
        assign osc_msb[g] = acc[g][ACC_W-1];
    end

    always_comb begin
        cur_freq = '0;
        cur_pw   = '0;
        cur_ctrl = '0;
        cur_acc  = '0;
        cur_lfsr = '0;
        cur_last = '0;
        cur_hold = '0;
        cur_nclk = 1'b0;
        src_d1   = 1'b0;
        src_d2   = 1'b0;
        for (int v = 0; v < VOICES; v++) begin
            if (slot == 3'(v)) begin
                cur_freq = freq[v];
                cur_pw   = pw[v];
                cur_ctrl = ctrl[v];
                cur_acc  = acc[v];
                cur_lfsr = lfsr[v];
                cur_last = last[v];
                cur_hold = hold[v];
                cur_nclk = nclk[v];
            end
            // Voice v is the sync/ring source of voice (v+1) mod VOICES.
            if (slot == 3'((v + 1) % VOICES)) begin
                src_d1 = msb_d1[v];
                src_d2 = msb_d2[v];
            end
        end

        test    = cur_ctrl[3];
        sync    = cur_ctrl[1] & src_d1 & ~src_d2;
        acc_nxt = (test || sync) ? '0 : cur_acc + ACC_W'(cur_freq);

        saw_w   = acc_nxt[ACC_W-1 -: WAVE_W];
        fold    = acc_nxt[ACC_W-1] ^ (cur_ctrl[2] & src_d1);
        tri_w   = {acc_nxt[ACC_W-2 -: WAVE_W-1] ^ {(WAVE_W-1){fold}}, 1'b0};
        pulse_w = (test || (acc_nxt[ACC_W-1 -: PW_W] >= cur_pw[11 -: PW_W])) ? '1 : '0;

        if (test)
            lfsr_nxt = '1;
        else if (!cur_nclk && acc_nxt[ACC_W-5])
            lfsr_nxt = {cur_lfsr[21:0], cur_lfsr[22] ^ cur_lfsr[17]};
        else
            lfsr_nxt = cur_lfsr;
        noise8  = {lfsr_nxt[20], lfsr_nxt[18], lfsr_nxt[14], lfsr_nxt[11],
                   lfsr_nxt[9], lfsr_nxt[5], lfsr_nxt[2], lfsr_nxt[0]};
        noise_w = WAVE_W'(noise8) << (WAVE_W - 8);

        mix = '1;
        if (cur_ctrl[4]) mix = mix & tri_w;
        if (cur_ctrl[5]) mix = mix & saw_w;
        if (cur_ctrl[6]) mix = mix & pulse_w;
        if (cur_ctrl[7]) mix = mix & noise_w;

        // With no waveform selected, keep emitting the last sample until the
        // hold counter runs out, then fall to silence.
        if (|cur_ctrl[7:4]) begin
            sample   = mix;
            last_nxt = mix;
            hold_nxt = HOLD_W'(HOLD_TTL);
        end else if (cur_hold != '0) begin
            sample   = cur_last;
            last_nxt = cur_last;
            hold_nxt = cur_hold - 1'b1;
        end else begin
            sample   = '0;
            last_nxt = cur_last;
            hold_nxt = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int v = 0; v < VOICES; v++) begin
                freq[v] <= '0;
                pw[v]   <= '0;
                ctrl[v] <= '0;
                acc[v]  <= '0;
                lfsr[v] <= '1;
                last[v] <= '0;
                hold[v] <= '0;
            end
            msb_d1    <= '0;
            msb_d2    <= '0;
            nclk      <= '0;
            state     <= ST_IDLE;
            slot      <= '0;
            overrun   <= 1'b0;
            out_valid <= 1'b0;
            out_voice <= '0;
            out_wave  <= '0;
        end else begin
            out_valid <= 1'b0;

            if (wr_en) begin
                for (int v = 0; v < VOICES; v++) begin
                    if (wr_voice == 3'(v)) begin
                        case (wr_reg)
                            3'd0:    freq[v][7:0]  <= wr_data;
                            3'd1:    freq[v][15:8] <= wr_data;
                            3'd2:    pw[v][7:0]    <= wr_data;
                            3'd3:    pw[v][11:8]   <= wr_data[3:0];
                            3'd4:    ctrl[v]       <= wr_data;
                            default: ;
                        endcase
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (ce_1m) begin
                        state  <= ST_RUN;
                        slot   <= '0;
                        // Snapshot all MSBs at burst start so sync timing does
                        // not depend on the order voices are processed.
                        msb_d1 <= osc_msb;
                        msb_d2 <= msb_d1;
                    end
                end
                ST_RUN: begin
                    if (ce_1m) overrun <= 1'b1;
                    for (int v = 0; v < VOICES; v++) begin
                        if (slot == 3'(v)) begin
                            acc[v]  <= acc_nxt;
                            lfsr[v] <= lfsr_nxt;
                            nclk[v] <= acc_nxt[ACC_W-5];
                            last[v] <= last_nxt;
                            hold[v] <= hold_nxt;
                        end
                    end
                    out_valid <= 1'b1;
                    out_voice <= slot;
                    out_wave  <= sample;
                    if (slot == 3'(VOICES - 1))
                        state <= ST_IDLE;
                    else
                        slot <= slot + 3'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sid_voice_bank.sv
// tb/tb_sid_voice_bank.sv - scoreboard testbench for sid_voice_bank
module tb_sid_voice_bank;

    localparam int VOICES = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_1m = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_voice = '0;
    logic [2:0]  wr_reg = '0;
    logic [7:0]  wr_data = '0;
    logic        out_valid;
    logic [2:0]  out_voice;
    logic [11:0] out_wave;
    logic [2:0]  osc_msb;
    logic        overrun;

    int compared = 0;
    int mismatched = 0;
    logic [14:0] exp_q[$];

    sid_voice_bank #(.VOICES(3), .ACC_W(24), .WAVE_W(12), .HOLD_TTL(4)) dut (
        .clock(clock), .reset_n(reset_n), .ce_1m(ce_1m), .wr_en(wr_en),
        .wr_voice(wr_voice), .wr_reg(wr_reg), .wr_data(wr_data),
        .out_valid(out_valid), .out_voice(out_voice), .out_wave(out_wave),
        .osc_msb(osc_msb), .overrun(overrun)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset_n && out_valid) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_sample: got voice %0d wave %03h, want none", out_voice, out_wave);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                if ({out_voice, out_wave} !== e) begin
                    mismatched++;
                    $display("FAIL sample: got voice %0d wave %03h, want voice %0d wave %03h",
                             out_voice, out_wave, e[14:12], e[11:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic push_tick(input logic [11:0] w0, input logic [11:0] w1, input logic [11:0] w2);
        exp_q.push_back({3'd0, w0});
        exp_q.push_back({3'd1, w1});
        exp_q.push_back({3'd2, w2});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ce_1m = 1'b0;
        wr_en = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic wr(input logic [2:0] v, input logic [2:0] r, input logic [7:0] d);
        wr_en = 1'b1; wr_voice = v; wr_reg = r; wr_data = d;
        @(posedge clock); #1;
        wr_en = 1'b0;
    endtask

    task automatic tick();
        ce_1m = 1'b1;
        @(posedge clock); #1;
        ce_1m = 1'b0;
        repeat (VOICES + 2) @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
        #1 check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] a0, a1, a;
        logic        d1, d2;

        // Reset state
        do_reset();
        check("reset_out_valid", out_valid, 0);
        check("reset_out_wave", out_wave, 0);
        check("reset_osc_msb", osc_msb, 0);
        check("reset_overrun", overrun, 0);

        // Sawtooth ramp on voice 1; freq write lands while voice 1 is in its slot
        wr(3'd5, 3'd4, 8'hFF);
        wr(3'd0, 3'd6, 8'hFF);
        wr(3'd1, 3'd4, 8'h20);
        push_tick(0, 0, 0);
        ce_1m = 1'b1;
        @(posedge clock); #1;
        ce_1m = 1'b0;
        @(posedge clock); #1;
        wr(3'd1, 3'd1, 8'h10);
        repeat (4) @(posedge clock);
        #1;
        for (int k = 1; k < 16; k++) begin
            push_tick(0, 12'(k), 0);
            tick();
        end
        drain("saw_drain");

        // Overrun with a tick every 2 clocks: only bursts at 0, 4, 8 accepted
        do_reset();
        check("overrun_before", overrun, 0);
        for (int i = 0; i < 9; i++) exp_q.push_back({3'(i % 3), 12'h000});
        for (int i = 0; i < 12; i++) begin
            ce_1m = (i % 2 == 0);
            @(posedge clock); #1;
        end
        ce_1m = 1'b0;
        check("overrun_set", overrun, 1);
        drain("overrun_drain");
        repeat (10) @(posedge clock);
        #1 check("overrun_sticky", overrun, 1);

        // Hard sync: voice 1 restarts one tick after voice 0 MSB rises
        do_reset();
        wr(3'd0, 3'd1, 8'h80);
        wr(3'd1, 3'd1, 8'h01);
        wr(3'd1, 3'd4, 8'h22);
        a0 = '0; a1 = '0; d1 = 0; d2 = 0;
        for (int k = 1; k <= 300; k++) begin
            d2 = d1;
            d1 = a0[23];
            a0 = a0 + 24'h8000;
            a1 = (d1 && !d2) ? 24'h0 : a1 + 24'h0100;
            push_tick(0, a1[23:12], 0);
            tick();
        end
        drain("sync_drain");

        // Test bit forces pulse high and holds acc; pulse threshold after release
        do_reset();
        wr(3'd0, 3'd1, 8'hF0);
        wr(3'd0, 3'd2, 8'h00);
        wr(3'd0, 3'd3, 8'h08);
        wr(3'd0, 3'd4, 8'h48);
        for (int k = 0; k < 3; k++) begin
            push_tick(12'hFFF, 0, 0);
            tick();
        end
        check("test_acc_msb", osc_msb, 0);
        wr(3'd0, 3'd4, 8'h40);
        for (int k = 1; k <= 140; k++) begin
            a = 24'(k * 24'hF000);
            push_tick((a[23:12] >= 12'h800) ? 12'hFFF : 12'h000, 0, 0);
            tick();
        end
        drain("pulse_drain");
        check("pulse_acc_msb", osc_msb, 3'b001);

        // Hold last sample for HOLD_TTL ticks after selects clear
        do_reset();
        wr(3'd2, 3'd1, 8'h10);
        wr(3'd2, 3'd4, 8'h20);
        for (int k = 1; k <= 3; k++) begin
            push_tick(0, 0, 12'(k));
            tick();
        end
        wr(3'd2, 3'd4, 8'h00);
        for (int k = 0; k < 6; k++) begin
            push_tick(0, 0, (k < 4) ? 12'h003 : 12'h000);
            tick();
        end
        drain("hold_drain");

        // Reset mid-burst at slot 1, then next burst starts at voice 0
        do_reset();
        wr(3'd1, 3'd4, 8'h20);
        ce_1m = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        ce_1m = 1'b0;
        check("midburst_overrun", overrun, 1);
        check("midburst_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_overrun", overrun, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        wr(3'd0, 3'd1, 8'h10);
        wr(3'd0, 3'd4, 8'h20);
        push_tick(12'h001, 0, 0);
        tick();
        drain("restart_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sid_voice_bank.md
SID_VOICE_BANK -- requirements
Module: sid_voice_bank

Interface
REQ-001 SHALL have parameter VOICES, default 3, number of time-multiplexed voices (2..8).
REQ-002 SHALL have parameter ACC_W, default 24, phase accumulator width (16..32).
REQ-003 SHALL have parameter WAVE_W, default 12, waveform output width (8..ACC_W-4).
REQ-004 SHALL have parameter HOLD_TTL, default 200000, number of ticks the last waveform is held after all waveform selects clear.
REQ-005 SHALL have port clock  input  1  system clock; the only clock.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous assert, active low.
REQ-007 SHALL have port ce_1m  input  1  tick strobe, one clock wide.
REQ-008 SHALL have port wr_en  input  1  register write strobe.
REQ-009 SHALL have port wr_voice  input  3  target voice index.
REQ-010 SHALL have port wr_reg  input  3  register select: 0 freq[7:0], 1 freq[15:8], 2 pw[7:0], 3 pw[11:8], 4 control[7:0].
REQ-011 SHALL have port wr_data  input  8  write data.
REQ-012 SHALL have port out_valid  output  1  one-cycle strobe per processed voice.
REQ-013 SHALL have port out_voice  output  3  voice index of current out_wave.
REQ-014 SHALL have port out_wave  output  WAVE_W  unsigned waveform sample.
REQ-015 SHALL have port osc_msb  output  VOICES  accumulator MSB of every voice.
REQ-016 SHALL have port overrun  output  1  sticky flag: ce_1m arrived while sequencer busy.

Function
REQ-017 SHALL hold per voice: freq[15:0], pw[11:0], control[7:0], acc[ACC_W-1:0], lfsr[22:0], msb_d1, msb_d2, noise-clock bit, last sample, hold counter.
REQ-018 SHALL apply writes in the cycle after wr_en; wr_voice >= VOICES ignored; wr_reg > 4 ignored; pw[11:8] takes wr_data[3:0].
REQ-019 SHALL run FSM IDLE/RUN: ce_1m in IDLE -> RUN with slot=0; slot increments every clock; slot=VOICES-1 -> IDLE.
REQ-020 SHALL ignore ce_1m in RUN and set overrun=1 until reset.
REQ-021 SHALL process voice `slot` in slot cycle and present its out_valid/out_voice/out_wave registered in the following cycle (latency 1 from slot, VOICES-cycle burst).
REQ-022 SHALL, on a write to the voice being processed in the same cycle, use pre-write register values for that tick.
REQ-023 SHALL update acc: 0 if control[3] (test) or sync; else acc + zero-extended freq, wrapping modulo 2^ACC_W.
REQ-024 SHALL define source(i) = (i+VOICES-1) mod VOICES; sync when control[1] and source msb_d1=1, msb_d2=0.
REQ-025 SHALL shift msb_d1/msb_d2 of all voices simultaneously on IDLE->RUN, so sync reacts one tick after source MSB rise, independent of slot order.
REQ-026 SHALL derive saw = new acc[ACC_W-1 -: WAVE_W].
REQ-027 SHALL derive tri = {acc[ACC_W-2 -: WAVE_W-1] XOR fold, 0}, fold = acc MSB XOR (control[2] AND source msb_d1).
REQ-028 SHALL derive pulse = all-ones if test or acc[ACC_W-1 -: 12] >= pw, else zero (WAVE_W<12: compare top WAVE_W bits against pw[11 -: WAVE_W]).
REQ-029 SHALL clock lfsr on 0->1 of acc[ACC_W-5]: lfsr <= {lfsr[21:0], lfsr[22] ^ lfsr[17]}; test forces lfsr to all-ones.
REQ-030 SHALL derive noise = {lfsr[20],[18],[14],[11],[9],[5],[2],[0]} MSB-aligned, zero-padded (WAVE_W=8: exact).
REQ-031 SHALL output bitwise AND of selected waveforms control[4]=tri, [5]=saw, [6]=pulse, [7]=noise.
REQ-032 SHALL, when control[7:4]=0, output last nonzero-select sample for HOLD_TTL ticks then 0; any select reloads hold counter.
REQ-033 SHALL drive osc_msb[i] = acc[i][ACC_W-1] continuously.

Reset
REQ-034 SHALL, on reset_n low, asynchronously clear acc, freq, pw, control, msb_d1/d2, samples, hold counters, overrun, out_valid, out_voice, out_wave; set lfsr all-ones; FSM IDLE.
REQ-035 SHALL abort any RUN burst at reset; first tick after release processes voice 0.

Verification
REQ-036 SHALL verify: VOICES=3, voice1 freq=0x1000, control=0x20, 16 ticks -> voice1 out_wave 0x000,0x001,...,0x00F, out_voice=1, one cycle after slot 1.
REQ-037 SHALL verify: ce_1m pulse each 2 clocks with VOICES=3 -> overrun=1, sticky, bursts unbroken.
REQ-038 SHALL verify: voice0 freq=0x8000, voice1 control=0x22 freq=0x0100 -> voice1 acc=0 on tick after each voice0 MSB rise.
REQ-039 SHALL verify: control=0x48, pw=0x800 -> out_wave all-ones, acc stays 0; clear test -> pulse 0 until acc top 12 bits reach 0x800.
REQ-040 SHALL verify: control 0x20 -> 0x00 with HOLD_TTL=4 -> last sample for 4 ticks, then 0x000.
REQ-041 SHALL verify: reset_n low mid-burst (slot 1) -> out_valid=0 immediately, overrun=0, next burst starts at voice 0.
